// File: rtl/cmd_dispatcher.sv
// rtl/cmd_dispatcher.sv - ASCII command line parser with one-hot channel dispatch and framed reply
module cmd_dispatcher #(
  parameter int NUM_CMDS       = 5,
  parameter int NAME_LEN       = 10,
  parameter logic [NUM_CMDS*NAME_LEN*8-1:0] CMD_TABLE =
    {"pb_i_stat_", "pb_i_reset", "pb_i_cfg__", "pb_i__read", "pb_i_write"},
  parameter int MAX_LINE       = 32,
  parameter int NUM_PARAMS     = 5,
  parameter int MAX_RSP        = 4,
  parameter int TIMEOUT_CYCLES = 2700000
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         rx_fifo_empty,
  input  logic [7:0]                   rx_fifo_data,
  output logic                         rx_fifo_read_en,
  input  logic                         tx_fifo_full,
  output logic [7:0]                   tx_fifo_data,
  output logic                         tx_fifo_write_en,
  output logic [NUM_CMDS-1:0]          cmd_active,
  input  logic [NUM_CMDS-1:0]          cmd_complete,
  output logic [NUM_PARAMS*8-1:0]      param_data,
  input  logic [$clog2(MAX_RSP+1)-1:0] rsp_count,
  input  logic [MAX_RSP*8-1:0]         rsp_data
);
  localparam int IW  = $clog2(MAX_LINE+1);
  localparam int BW  = $clog2(MAX_LINE);
  localparam int TCW = $clog2(TIMEOUT_CYCLES+1);
  localparam int RCW = $clog2(MAX_RSP+1);
  localparam int TXW = $clog2(NAME_LEN+3+2*MAX_RSP+1);
  localparam int SW  = (NUM_CMDS > 1) ? $clog2(NUM_CMDS) : 1;
  localparam logic [TCW-1:0] T_LAST = TCW'(TIMEOUT_CYCLES-1);

  typedef enum logic [1:0] {S_RX, S_PARSE, S_WAIT, S_TX} state_t;
  state_t state, state_nxt;

  logic [7:0]              line_buf [MAX_LINE];
  logic [IW-1:0]           line_len;
  logic                    ovf, pop_q, is_err;
  logic [SW-1:0]           sel, hit_idx;
  logic [TCW-1:0]          tcnt;
  logic [7:0]              err_code, parse_code, tx_byte;
  logic [RCW-1:0]          rsp_len;
  logic [MAX_RSP*8-1:0]    rsp_buf;
  logic [TXW-1:0]          tx_idx, tx_len;
  logic [NUM_PARAMS*8-1:0] parse_params;
  logic [NUM_CMDS-1:0]     sel_onehot;
  logic [NAME_LEN*8-1:0]   sel_name;
  logic [4:0]              dec;
  logic                    name_hit, name_eq, comma_ok, hex_ok;
  logic                    rx_pop, rx_term, complete_seen, timed_out, tx_push, tx_last;
  int                      ti, hj;

  function automatic logic [4:0] hex_decode(input logic [7:0] c);
    if (c >= 8'h30 && c <= 8'h39) return {1'b1, c[3:0]};
    if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66)) return {1'b1, c[3:0] + 4'd9};
    return 5'd0;
  endfunction

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  assign rx_pop        = (state == S_RX) && !rx_fifo_empty && !pop_q;
  assign rx_term       = (rx_fifo_data == 8'h0D) || (rx_fifo_data == 8'h0A);
  assign sel_onehot    = NUM_CMDS'(1) << sel;
  assign sel_name      = CMD_TABLE[int'(sel)*NAME_LEN*8 +: NAME_LEN*8];
  assign complete_seen = |(cmd_complete & sel_onehot);
  assign timed_out     = (tcnt == T_LAST);
  assign tx_len        = is_err ? TXW'(8) : TXW'(NAME_LEN+3) + TXW'({rsp_len, 1'b0});
  assign tx_push       = (state == S_TX) && !tx_fifo_full;
  assign tx_last       = (tx_idx == tx_len - TXW'(1));

  // Descending scan so the lowest matching table entry is the one left in hit_idx.
  always_comb begin
    name_hit = 1'b0;
    hit_idx  = '0;
    name_eq  = 1'b0;
    for (int k = NUM_CMDS-1; k >= 0; k--) begin
      name_eq = 1'b1;
      for (int i = 0; i < NAME_LEN; i++)
        if (line_buf[i] != CMD_TABLE[(k+1)*NAME_LEN*8-1-i*8 -: 8]) name_eq = 1'b0;
      if (name_eq) begin
        name_hit = 1'b1;
        hit_idx  = SW'(k);
      end
    end
    comma_ok     = (int'(line_len) > NAME_LEN) && (line_buf[NAME_LEN] == 8'h2C);
    hex_ok       = 1'b1;
    parse_params = '0;
    dec          = '0;
    for (int p = 0; p < 2*NUM_PARAMS; p++) begin
      if (NAME_LEN+1+p < MAX_LINE && NAME_LEN+1+p < int'(line_len)) begin
        dec = hex_decode(line_buf[NAME_LEN+1+p]);
        if (!dec[4]) hex_ok = 1'b0;
        parse_params[(p/2)*8 + ((p%2 == 0) ? 4 : 0) +: 4] = dec[3:0];
      end
    end
    parse_code = !(name_hit && comma_ok) ? 8'h02 : (!hex_ok ? 8'h03 : 8'h00);
  end

  always_comb begin
    tx_byte = 8'h0A;
    ti      = int'(tx_idx);
    hj      = 0;
    if (is_err) begin
      case (ti)
        0:       tx_byte = 8'h45;
        1, 2:    tx_byte = 8'h52;
        3:       tx_byte = 8'h2C;
        4:       tx_byte = hex_char(err_code[7:4]);
        5:       tx_byte = hex_char(err_code[3:0]);
        6:       tx_byte = 8'h0D;
        default: tx_byte = 8'h0A;
      endcase
    end else if (ti < NAME_LEN) begin
      tx_byte = sel_name[(NAME_LEN-1-ti)*8 +: 8];
    end else if (ti == NAME_LEN) begin
      tx_byte = 8'h2C;
    end else if (ti < NAME_LEN+1+2*int'(rsp_len)) begin
      hj      = ti - NAME_LEN - 1;
      tx_byte = hex_char(rsp_buf[(hj/2)*8 + ((hj%2 == 0) ? 4 : 0) +: 4]);
    end else if (ti == NAME_LEN+1+2*int'(rsp_len)) begin
      tx_byte = 8'h0D;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) state <= S_RX;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_RX:    if (rx_pop && rx_term && (ovf || line_len != '0)) state_nxt = ovf ? S_TX : S_PARSE;
      S_PARSE: state_nxt = (parse_code == 8'h00) ? S_WAIT : S_TX;
      S_WAIT:  if (complete_seen || timed_out) state_nxt = S_TX;
      S_TX:    if (tx_push && tx_last) state_nxt = S_RX;
      default: state_nxt = S_RX;
    endcase
  end

  always_comb begin
    rx_fifo_read_en  = reset_n && rx_pop;
    tx_fifo_write_en = reset_n && tx_push;
    tx_fifo_data     = tx_byte;
    cmd_active       = (state == S_WAIT) ? sel_onehot : '0;
  end

  always_ff @(posedge clock) begin
    if (reset_n && rx_pop && !rx_term && !ovf && int'(line_len) < MAX_LINE)
      line_buf[line_len[BW-1:0]] <= rx_fifo_data;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      line_len   <= '0;
      ovf        <= 1'b0;
      pop_q      <= 1'b0;
      sel        <= '0;
      param_data <= '0;
      tcnt       <= '0;
      is_err     <= 1'b0;
      err_code   <= '0;
      rsp_len    <= '0;
      rsp_buf    <= '0;
      tx_idx     <= '0;
    end else begin
      pop_q <= rx_pop;
      case (state)
        S_RX: if (rx_pop) begin
          if (rx_term) begin
            if (ovf) begin
              is_err   <= 1'b1;
              err_code <= 8'h01;
              ovf      <= 1'b0;
              tx_idx   <= '0;
              rsp_len  <= '0;
            end
          end else if (int'(line_len) == MAX_LINE) begin
            ovf <= 1'b1;
          end else begin
            line_len <= line_len + IW'(1);
          end
        end
        S_PARSE: begin
          tx_idx  <= '0;
          tcnt    <= '0;
          rsp_len <= '0;
          if (parse_code == 8'h00) begin
            is_err     <= 1'b0;
            param_data <= parse_params;
            sel        <= hit_idx;
          end else begin
            is_err   <= 1'b1;
            err_code <= parse_code;
          end
        end
        S_WAIT: begin
          if (complete_seen) begin
            rsp_len <= (int'(rsp_count) > MAX_RSP) ? RCW'(MAX_RSP) : rsp_count;
            rsp_buf <= rsp_data;
          end else if (timed_out) begin
            is_err   <= 1'b1;
            err_code <= 8'h04;
          end else begin
            tcnt <= tcnt + TCW'(1);
          end
        end
        S_TX: if (tx_push) begin
          if (tx_last) begin
            tx_idx   <= '0;
            line_len <= '0;
          end else begin
            tx_idx <= tx_idx + TXW'(1);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_cmd_dispatcher.sv
// tb/tb_cmd_dispatcher.sv - directed table-driven bench for cmd_dispatcher
module tb_cmd_dispatcher;
  localparam int NC = 5;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        rx_fifo_empty;
  logic [7:0]  rx_fifo_data;
  logic        rx_fifo_read_en;
  logic        tx_fifo_full;
  logic [7:0]  tx_fifo_data;
  logic        tx_fifo_write_en;
  logic [NC-1:0] cmd_active;
  logic [NC-1:0] cmd_complete;
  logic [39:0] param_data;
  logic [2:0]  rsp_count;
  logic [31:0] rsp_data;

  cmd_dispatcher #(.TIMEOUT_CYCLES(100)) dut (
    .clock(clock), .reset_n(reset_n),
    .rx_fifo_empty(rx_fifo_empty), .rx_fifo_data(rx_fifo_data), .rx_fifo_read_en(rx_fifo_read_en),
    .tx_fifo_full(tx_fifo_full), .tx_fifo_data(tx_fifo_data), .tx_fifo_write_en(tx_fifo_write_en),
    .cmd_active(cmd_active), .cmd_complete(cmd_complete), .param_data(param_data),
    .rsp_count(rsp_count), .rsp_data(rsp_data)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       line;
    int          delay;
    int          cnt;
    logic [31:0] dat;
    logic [4:0]  act;
    logic [39:0] prm;
    int          cycles;
    string       tx;
    int          late;
    int          stall_at;
    int          stall_len;
  } vec_t;

  logic [7:0] rx_q[$];
  logic [7:0] tx_got[$];
  int total = 0;
  int bad = 0;
  int pop_viol = 0;
  bit rd_prev = 1'b0;
  vec_t vecs[10];

  // FIFO models: pop/push on the edge, head/empty refreshed shortly after it.
  always @(posedge clock) begin
    if (rx_fifo_read_en && rd_prev) pop_viol++;
    rd_prev = rx_fifo_read_en;
    if (rx_fifo_read_en && rx_q.size() > 0) void'(rx_q.pop_front());
    if (tx_fifo_write_en) tx_got.push_back(tx_fifo_data);
    #2;
    rx_fifo_empty = (rx_q.size() == 0);
    rx_fifo_data  = rx_fifo_empty ? 8'h00 : rx_q[0];
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic string vis(input string s);
    string r = "";
    for (int i = 0; i < s.len(); i++) begin
      if (s[i] == 8'h0D)      r = {r, "<CR>"};
      else if (s[i] == 8'h0A) r = {r, "<LF>"};
      else                    r = $sformatf("%s%c", r, s[i]);
    end
    return r;
  endfunction

  function automatic vec_t mk(input string line, input int delay, input int cnt, input logic [31:0] dat,
                              input logic [4:0] act, input logic [39:0] prm, input int cycles, input string tx);
    vec_t v;
    v.line = line; v.delay = delay; v.cnt = cnt; v.dat = dat; v.act = act; v.prm = prm;
    v.cycles = cycles; v.tx = tx; v.late = 0; v.stall_at = 0; v.stall_len = 0;
    return v;
  endfunction

  task automatic run_vec(input string tag, input vec_t v);
    int act_cycles = 0, rises = 0, since_drop = 0, stall_left = 0, quiet = 0;
    bit seen = 0, stalled = 0, was_act = 0;
    logic [NC-1:0] first_act = '0;
    logic [39:0] first_param = '0;
    string got = "";
    tx_got.delete();
    for (int i = 0; i < v.line.len(); i++) rx_q.push_back(v.line[i]);
    for (int c = 0; c < 600 && quiet < 20; c++) begin
      @(negedge clock);
      cmd_complete = '0;
      if (cmd_active != '0) begin
        if (!was_act) rises++;
        if (!seen) begin
          first_act = cmd_active; first_param = param_data; seen = 1;
        end
        if (act_cycles == v.delay) begin
          cmd_complete = v.act; rsp_count = 3'(v.cnt); rsp_data = v.dat;
        end
        act_cycles++;
      end else if (seen) begin
        since_drop++;
        if (since_drop == v.late) cmd_complete = v.act;
      end
      was_act = (cmd_active != '0);
      if (stall_left > 0) begin
        stall_left--;
        if (stall_left == 0) tx_fifo_full = 1'b0;
      end else if (!stalled && v.stall_len > 0 && tx_got.size() == v.stall_at) begin
        tx_fifo_full = 1'b1; stall_left = v.stall_len; stalled = 1;
      end
      if (tx_got.size() >= v.tx.len()) quiet++;
    end
    cmd_complete = '0;
    foreach (tx_got[i]) got = $sformatf("%s%c", got, tx_got[i]);
    total++;
    if (vis(got) != vis(v.tx)) begin
      bad++;
      $display("FAIL %s_tx: got \"%s\" expected \"%s\"", tag, vis(got), vis(v.tx));
    end
    check({tag, "_rises"}, rises, (v.act != '0) ? 1 : 0);
    if (v.act != '0) begin
      check({tag, "_active"}, first_act, v.act);
      check({tag, "_param"}, first_param, v.prm);
      check({tag, "_act_cycles"}, act_cycles, v.cycles);
    end
  endtask

  initial begin
    vec_t v;
    string s;
    bit ok;
    reset_n = 1'b0; rx_fifo_empty = 1'b1; rx_fifo_data = '0; tx_fifo_full = 1'b0;
    cmd_complete = '0; rsp_count = '0; rsp_data = '0;

    vecs[0] = mk("pb_i_write,0102030405\r", 10, 0, 32'h0, 5'b00001, 40'h0504030201, 11, "pb_i_write,\r\n");
    vecs[1] = mk("pb_i__read,00\r", 3, 4, 32'hDEADBEEF, 5'b00010, 40'h0, 4, "pb_i__read,EFBEADDE\r\n");
    vecs[1].stall_at = 5; vecs[1].stall_len = 20;
    vecs[2] = mk("foo_______,00\r", -1, 0, 32'h0, 5'b00000, 40'h0, 0, "ERR,02\r\n");
    vecs[3] = mk("pb_i_write,0G\r", -1, 0, 32'h0, 5'b00000, 40'h0, 0, "ERR,03\r\n");
    vecs[4] = mk("pb_i_cfg__,aB\n", 0, 6, 32'h01234567, 5'b00100, 40'hAB, 1, "pb_i_cfg__,67452301\r\n");
    vecs[5] = mk("pb_i_reset\r", -1, 0, 32'h0, 5'b00000, 40'h0, 0, "ERR,02\r\n");
    vecs[6] = mk("pb_i_stat_,1\r", 5, 1, 32'hA5, 5'b10000, 40'h10, 6, "pb_i_stat_,A5\r\n");
    vecs[7] = mk("\r\npb_i__read,FF\r", 2, 2, 32'h0C3B, 5'b00010, 40'hFF, 3, "pb_i__read,3B0C\r\n");
    vecs[8] = mk("pb_i__read,12\r", 1000, 0, 32'h0, 5'b00010, 40'h12, 100, "ERR,04\r\n");
    vecs[8].late = 5;
    vecs[9] = mk("pb_i_write,0102030405060708090A0\r", 1, 0, 32'h0, 5'b00001, 40'h0504030201, 2, "pb_i_write,\r\n");

    repeat (3) @(negedge clock);
    check("reset_active", cmd_active, '0);
    check("reset_rd", rx_fifo_read_en, 0);
    check("reset_wr", tx_fifo_write_en, 0);
    check("reset_param", param_data, '0);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);

    for (int i = 0; i < 10; i++) run_vec($sformatf("v%0d", i), vecs[i]);

    // reset while a channel is busy: abandon the command silently
    tx_got.delete();
    s = "pb_i_write,00\r";
    for (int i = 0; i < s.len(); i++) rx_q.push_back(s[i]);
    ok = 0;
    for (int c = 0; c < 300 && !ok; c++) begin
      @(negedge clock);
      if (cmd_active != '0) ok = 1;
    end
    check("rst_dispatch", ok, 1);
    reset_n = 1'b0;
    @(negedge clock);
    check("rst_active", cmd_active, '0);
    check("rst_param", param_data, '0);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (30) @(negedge clock);
    check("rst_no_tx", tx_got.size(), 0);
    check("rst_idle", cmd_active, '0);

    // 40-byte unterminated line, then recovery on the next line
    s = "";
    repeat (40) s = {s, "x"};
    v = mk({s, "\n"}, -1, 0, 32'h0, 5'b00000, 40'h0, 0, "ERR,01\r\n");
    run_vec("ovf", v);
    v = mk("pb_i_write,00\r", 1, 0, 32'h0, 5'b00001, 40'h0, 2, "pb_i_write,\r\n");
    run_vec("ovf_next", v);

    check("pop_rate", pop_viol, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
